// File: rtl/pc_unit_if.sv
// Fetch-stage PC unit bus: control/operand inputs and registered PC/RAS status outputs.
// The master drives the next-PC request; the slave is the PC unit itself.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [2:0]       op;
  logic             cond;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             redirect;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  modport master (
    output en, op, cond, offset, target,
    input  pc, pc_plus, redirect, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  en, op, cond, offset, target,
    output pc, pc_plus, redirect, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection (seq/branch/jump/call/return/trap)
// and a circular return-address stack whose oldest entry is overwritten on overflow.
module pc_unit #(
  parameter int unsigned    WIDTH     = 32,
  parameter int unsigned    STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]    TRAP_VEC  = 32'h0000_0080,
  parameter int unsigned    RAS_DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  pc_unit_if.slave   bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VEC);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_BRANCH = 3'b001,
    OP_JUMP   = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100,
    OP_TRAP   = 3'b101
  } op_e;

  logic [WIDTH-1:0] pcReg;
  logic [WIDTH-1:0] pcPlusReg;
  logic             redirectReg;
  logic             rasErrReg;
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] ras [RAS_DEPTH];

  logic [WIDTH-1:0] pcNext;
  logic             redirectNext;
  logic             rasErrNext;
  logic [PTR_W-1:0] topNext;
  logic [CNT_W-1:0] countNext;
  logic             pushEn;

  // pcPlusReg already holds pc + STEP, so it doubles as the sequential target and call return address.
  always_comb begin
    pcNext       = pcPlusReg;
    redirectNext = 1'b0;
    rasErrNext   = 1'b0;
    topNext      = top;
    countNext    = count;
    pushEn       = 1'b0;
    case (bus.op)
      OP_BRANCH: begin
        if (bus.cond) begin
          pcNext       = pcReg + bus.offset;
          redirectNext = 1'b1;
        end
      end
      OP_JUMP: begin
        pcNext       = bus.target;
        redirectNext = 1'b1;
      end
      OP_CALL: begin
        pushEn       = 1'b1;
        topNext      = top + 1'b1;
        pcNext       = bus.target;
        redirectNext = 1'b1;
        if (count == FULL_CNT) begin
          rasErrNext = 1'b1;
        end else begin
          countNext = count + 1'b1;
        end
      end
      OP_RET: begin
        redirectNext = 1'b1;
        if (count == '0) begin
          pcNext     = TRAP_PC;
          rasErrNext = 1'b1;
        end else begin
          pcNext    = ras[top];
          topNext   = top - 1'b1;
          countNext = count - 1'b1;
        end
      end
      OP_TRAP: begin
        pcNext       = TRAP_PC;
        redirectNext = 1'b1;
      end
      default: ;
    endcase
  end

  // A stall holds PC and stack but still clears the one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg       <= RESET_PC;
      pcPlusReg   <= RESET_PC + STEP_W;
      redirectReg <= 1'b0;
      rasErrReg   <= 1'b0;
      top         <= '0;
      count       <= '0;
    end else if (bus.en) begin
      pcReg       <= pcNext;
      pcPlusReg   <= pcNext + STEP_W;
      redirectReg <= redirectNext;
      rasErrReg   <= rasErrNext;
      top         <= topNext;
      count       <= countNext;
    end else begin
      redirectReg <= 1'b0;
      rasErrReg   <= 1'b0;
    end
  end

  // Stack storage needs no reset: the occupancy count decides which entries are valid.
  always_ff @(posedge clk) begin
    if (bus.en && pushEn) begin
      ras[topNext] <= pcPlusReg;
    end
  end

  assign bus.pc        = pcReg;
  assign bus.pc_plus   = pcPlusReg;
  assign bus.redirect  = redirectReg;
  assign bus.ras_err   = rasErrReg;
  assign bus.ras_empty = (count == '0);
  assign bus.ras_full  = (count == FULL_CNT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then randomized traffic
// compared against a queue-based model of the PC and return-address stack.
module tb_pc_unit;
  localparam int          WIDTH = 32;
  localparam int          STEP  = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] TRAP  = 32'h0000_0080;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pc_unit_if #(.WIDTH(WIDTH)) bus ();

  pc_unit #(
    .WIDTH(WIDTH), .STEP(STEP), .RESET_PC('0), .TRAP_VEC(TRAP), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] mPc;
  logic        mRedirect;
  logic        mErr;
  logic [31:0] mRas[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " pc"}, bus.pc, mPc);
    checkOutput({tag, " pc_plus"}, bus.pc_plus, mPc + 32'(STEP));
    checkOutput({tag, " redirect"}, {31'b0, bus.redirect}, {31'b0, mRedirect});
    checkOutput({tag, " ras_err"}, {31'b0, bus.ras_err}, {31'b0, mErr});
    checkOutput({tag, " ras_empty"}, {31'b0, bus.ras_empty}, {31'b0, mRas.size() == 0});
    checkOutput({tag, " ras_full"}, {31'b0, bus.ras_full}, {31'b0, mRas.size() == DEPTH});
  endtask

  task automatic modelReset();
    mPc       = 32'h0;
    mRedirect = 1'b0;
    mErr      = 1'b0;
    mRas.delete();
  endtask

  // Stack kept as a queue: newest at the back, oldest dropped from the front on overflow.
  task automatic modelStep(input logic e, input logic [2:0] o, input logic c,
                           input logic [31:0] off, input logic [31:0] tgt);
    mRedirect = 1'b0;
    mErr      = 1'b0;
    if (e) begin
      case (o)
        3'd1: begin
          if (c) begin mPc = mPc + off; mRedirect = 1'b1; end
          else mPc = mPc + 32'(STEP);
        end
        3'd2: begin mPc = tgt; mRedirect = 1'b1; end
        3'd3: begin
          mRas.push_back(mPc + 32'(STEP));
          if (mRas.size() > DEPTH) begin
            void'(mRas.pop_front());
            mErr = 1'b1;
          end
          mPc = tgt;
          mRedirect = 1'b1;
        end
        3'd4: begin
          mRedirect = 1'b1;
          if (mRas.size() == 0) begin mPc = TRAP; mErr = 1'b1; end
          else mPc = mRas.pop_back();
        end
        3'd5: begin mPc = TRAP; mRedirect = 1'b1; end
        default: mPc = mPc + 32'(STEP);
      endcase
    end
  endtask

  task automatic applyStimulus(input string tag, input logic e, input logic [2:0] o, input logic c,
                               input logic [31:0] off, input logic [31:0] tgt);
    bus.en     = e;
    bus.op     = o;
    bus.cond   = c;
    bus.offset = off;
    bus.target = tgt;
    @(posedge clk);
    modelStep(e, o, c, off, tgt);
    #1;
    checkAll(tag);
  endtask

  // Reset is pulsed between edges so its asynchronous effect is observed before any clock.
  task automatic pulseReset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.en = 1'b0; bus.op = 3'd0; bus.cond = 1'b0; bus.offset = '0; bus.target = '0;
    modelReset();
    #12;
    checkAll("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus("seq", 1'b1, 3'd0, 1'b0, 32'h0, 32'h0);

    applyStimulus("jump100", 1'b1, 3'd2, 1'b0, 32'h0, 32'h100);
    applyStimulus("br_taken", 1'b1, 3'd1, 1'b1, 32'hFFFF_FFF0, 32'h0);
    applyStimulus("br_not", 1'b1, 3'd1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    applyStimulus("br_step", 1'b1, 3'd1, 1'b1, 32'h4, 32'h0);

    applyStimulus("jump_top", 1'b1, 3'd2, 1'b0, 32'h0, 32'hFFFF_FFFC);
    applyStimulus("wrap", 1'b1, 3'd0, 1'b0, 32'h0, 32'h0);
    applyStimulus("reserved", 1'b1, 3'd6, 1'b0, 32'h0, 32'h0);

    applyStimulus("jump10", 1'b1, 3'd2, 1'b0, 32'h0, 32'h10);
    applyStimulus("call200", 1'b1, 3'd3, 1'b0, 32'h0, 32'h200);
    applyStimulus("call300", 1'b1, 3'd3, 1'b0, 32'h0, 32'h300);
    applyStimulus("ret1", 1'b1, 3'd4, 1'b0, 32'h0, 32'h0);
    applyStimulus("ret2", 1'b1, 3'd4, 1'b0, 32'h0, 32'h0);

    for (int i = 1; i <= 5; i++) applyStimulus("ovf_call", 1'b1, 3'd3, 1'b0, 32'h0, 32'(i) << 12);
    for (int i = 0; i < 5; i++) applyStimulus("ovf_ret", 1'b1, 3'd4, 1'b0, 32'h0, 32'h0);

    applyStimulus("trap", 1'b1, 3'd5, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b0, 3'd2, 1'b0, 32'h0, 32'h4444);

    applyStimulus("pre_rst_call", 1'b1, 3'd3, 1'b0, 32'h0, 32'h500);
    applyStimulus("pre_rst_call", 1'b1, 3'd3, 1'b0, 32'h0, 32'h600);
    pulseReset("mid_reset");
    applyStimulus("post_rst_ret", 1'b1, 3'd4, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic        e;
      logic [2:0]  o;
      logic [31:0] off;
      e   = ($urandom_range(0, 9) != 0);
      o   = 3'($urandom_range(0, 7));
      off = ($urandom_range(0, 1) == 0) ? $urandom : (32'($urandom_range(0, 63)) - 32'd32) << 2;
      applyStimulus("rand", e, o, 1'($urandom_range(0, 1)), off, $urandom);
      if ($urandom_range(0, 99) == 0) pulseReset("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the microprocessor fetch stage. It replaces the fixed registered PC adder with a single block that holds the PC register and selects the next PC: sequential increment, conditional relative branch, absolute jump, call/return through an internal return-address stack (RAS), and trap vectoring. All outputs are registered and feed instruction memory and the DMA/bus arbitration logic directly.

## Interface
- WIDTH, 32, PC and address width in bits
- STEP, 4, sequential increment added to PC
- RESET_PC, 0, PC value after reset
- TRAP_VEC, 32'h0000_0080, PC loaded on trap or RAS underflow (truncated to WIDTH)
- RAS_DEPTH, 4, return-address stack entries (power of two, at least 2)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  advance enable; 0 = stall, all state held
- op  in  3  next-PC operation: 000 seq, 001 branch, 010 jump, 011 call, 100 return, 101 trap, 110/111 reserved
- cond  in  1  branch taken flag, used only by op=001
- offset  in  WIDTH  two's-complement branch displacement
- target  in  WIDTH  absolute jump or call address
- pc  out  WIDTH  current PC, registered
- pc_plus  out  WIDTH  pc + STEP, registered alongside pc
- redirect  out  1  one-cycle pulse: the last update was non-sequential
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_err  out  1  one-cycle pulse on RAS overflow or underflow

## Operation
- All arithmetic is modulo 2^WIDTH. No alignment checks; wrap-around is silent.
- With en=1 at a rising edge, the next PC is selected as follows:
  - seq, or any reserved op: pc + STEP.
  - branch: pc + offset when cond=1, otherwise pc + STEP.
  - jump: target.
  - call: push pc + STEP onto the RAS, then target.
  - return: pop the top of the RAS. If the RAS is empty, load TRAP_VEC and pulse ras_err.
  - trap: TRAP_VEC. The RAS is untouched.
- pc_plus is always the registered new pc + STEP.
- RAS organisation:
  - Circular buffer with a top pointer and an occupancy count saturating at RAS_DEPTH.
  - Call when full overwrites the oldest entry. Count stays at RAS_DEPTH and ras_err pulses.
  - A later return still yields the newest entries in LIFO order.
- redirect=1 after any update other than seq, a reserved op, or a not-taken branch.
  - A taken branch with offset=STEP still pulses redirect.
- With en=0, pc, pc_plus and the RAS hold. redirect and ras_err go to 0 at that edge.

## Timing
- Reset (asynchronous, takes effect immediately when rst_n falls):
  - pc=RESET_PC, pc_plus=RESET_PC+STEP
  - RAS count=0, so ras_empty=1 and ras_full=0
  - redirect=0, ras_err=0
- Release of rst_n is sampled at a rising edge. The first update occurs on the first edge with rst_n=1 and en=1.
- Reset asserted mid-operation discards the RAS contents and any pending pulses.
- Latency is one cycle: inputs sampled at edge N appear on pc, pc_plus, redirect, ras_* after edge N.
- redirect and ras_err are high for exactly the one cycle following the causing edge. They are never sticky.
- ras_empty and ras_full reflect the count after the same edge.
- Inputs op, cond, offset and target need to be valid only at edges where en=1.

## Test plan
- Reset, then 3 edges of seq with en=1 (defaults): pc goes 0 → 4 → 8 → 12; redirect=0; ras_empty=1.
- Branches from pc=0x100:
  - cond=1, offset=0xFFFF_FFF0: pc=0x0F0, redirect=1 for one cycle.
  - Next cycle cond=0: pc=0x0F4, redirect=0.
- Wrap-around: from pc=0xFFFF_FFFC, seq gives pc=0 and pc_plus=4.
- Nested calls:
  - From pc=0x10, call target=0x200, then call target=0x300: RAS holds 0x14 and 0x204.
  - First return gives pc=0x204, second gives 0x14.
  - ras_empty=1 after the second return.
- RAS overflow: 5 calls with RAS_DEPTH=4.
  - The 5th call pulses ras_err while ras_full stays 1.
  - 4 returns yield the newest 4 return addresses.
  - A 5th return gives pc=0x80 with ras_err=1.
- Stall and reset mid-stream:
  - en=0 for 3 cycles with op=jump: pc held, redirect=0.
  - rst_n pulsed low between edges after 2 calls: pc=RESET_PC immediately and ras_empty=1.
